rand_stream_sched: RTL and testbench
====================================

# rand_stream_sched

Round-robin scheduler that shares the single multi-stream random number generator among NREQ requesters. Each requester owns a generator stream. The scheduler runs a complete get-next transaction on the generator's bus slave port for the granted requester: select stream, read value, advance state. It returns the 32-bit value with a one-cycle done pulse. It sits between CPU/peripheral requesters and the generator; nothing else may drive the generator's bus port.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..16).
- GAP, 2: idle cycles forced between generator bus cycles (≥1). This covers the generator's write-edge detection and stream-RAM settle time.
- TMO, 255: cycles to wait for m_ack_i before a bus cycle is aborted.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NREQ  level request per requester; held until its done_o pulse.
- stream_i  in  NREQ*10  packed stream number per requester; slice i is sampled at grant.
- done_o  out  NREQ  one-cycle pulse, one-hot, for the requester served.
- err_o  out  1  valid only with done_o; 1 means the transaction timed out.
- rnd_o  out  32  random value; updated on done_o; held otherwise.
- busy_o  out  1  high from grant through the DONE state.
- m_cs_o, m_cyc_o, m_stb_o, m_we_o  out  1 each  generator bus strobes.
- m_adr_o  out  4  register offset.
- m_dat_o  out  32  write data.
- m_ack_i  in  1  generator acknowledge.
- m_dat_i  in  32  generator read data.

## Operation
- Reset values: done_o=0, err_o=0, rnd_o=0, busy_o=0, all m_* outputs 0, state=IDLE, RR pointer=0, stream cache invalid.
- IDLE: if any req_i bit is set, the rr_arbiter picks the first set bit at or after the pointer, wrapping. The scheduler latches the index g and stream_i[g], sets the pointer to g+1 mod NREQ, then goes to WSTR if the cache is invalid or differs from the latched stream, else to RD.
- WSTR: write, adr=4'h4, dat={22'h0,stream}. On ack, update the cache, then GAP, then RD.
- RD: read, adr=4'h0. rnd_o is not changed here; the data is captured into a holding register on the ack cycle. Then GAP, then WADV.
- WADV: write, adr=4'h0, dat=0; this advances the stream. On ack, GAP, then DONE.
- GAP: all m_* outputs 0 for exactly GAP cycles. we is therefore low between consecutive writes.
- DONE: one cycle. done_o[g]=1, rnd_o=holding register, err_o=result. Then IDLE.
- Bus states: cs/cyc/stb are held asserted, with stable adr/dat/we, until the ack cycle inclusive.
- Timeout: a cycle counter is cleared on entering each bus state. When it reaches TMO without ack:
  - drop the bus and run GAP;
  - then DONE with err_o=1 and rnd_o=0;
  - invalidate the stream cache;
  - skip the remaining steps.
- Withdrawn request: if req_i[g] falls mid-transaction, the transaction still completes and done_o[g] still pulses.
- A new request that arrives during a transaction waits. Arbitration happens only in IDLE.
- The pointer only advances on grant. A lone requester is served back-to-back with one IDLE cycle between transactions.
- Async reset mid-transaction: all m_* outputs drop immediately, no done_o pulse is issued, and the cache is invalidated.

## Timing
- Let A be the number of cycles a bus state lasts, including the ack cycle.
- Grant-to-done:
  - with stream change: 1 (IDLE) + 3·(A+GAP) + 1 (DONE) cycles;
  - same stream: 2·(A+GAP) + 2 cycles.
- Example, A=2 and GAP=2: 14 cycles with a stream change, 10 cycles with the same stream.
- done_o and rnd_o change on the same clock edge. Exactly one done_o pulse per grant.
- Timeout path: 1 + k·(A+GAP) + (TMO+GAP) + 1 cycles, where k is the number of completed bus steps before the failing one.

## Structure
- Package rand_sched_pkg holds:
  - state enum {IDLE, WSTR, RD, WADV, GAP, DONE}, plus the return-state register type;
  - constants RNG_ADR_VALUE=4'h0 and RNG_ADR_STREAM=4'h4.
- Sub-module rr_arbiter #(NREQ): inputs req and ptr; outputs a one-hot grant and its binary index. It is combinational; the pointer register stays in the parent.
- The top holds the FSM, GAP/TMO counters, holding register and stream cache.

## Test plan
- Single request, stream 5, generator model returning 32'hDEADBEEF with A=2, GAP=2: sequence is W@4 (5), R@0, W@0; done_o=0001 at grant+14; rnd_o=DEADBEEF; err_o=0.
- Same requester, same stream again: no W@4 issued; done at grant+10.
- req_i=1111 held: grants in order 0,1,2,3,0; each done_o pulse is one-hot; m_we_o is low for ≥2 cycles between any two writes.
- Model never acks RD, TMO=255: bus drops after 255 cycles; done_o pulses with err_o=1 and rnd_o=0; next grant re-issues W@4.
- rst_ni low during RD: m_cyc_o=0 within the same cycle; no done_o; after release, W@4 is issued even for the previous stream.
- req_i[2] dropped during WADV: done_o[2] still pulses; no further grant to requester 2.

Source files
------------

// File: rtl/rand_sched_pkg.sv
// rand_sched_pkg: shared types and register map for the random-stream scheduler
package rand_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WSTR,
      ST_RD,
      ST_WADV,
      ST_GAP,
      ST_DONE
   } state_t;

   typedef state_t ret_state_t;

   localparam logic [3:0] RNG_ADR_VALUE  = 4'h0;
   localparam logic [3:0] RNG_ADR_STREAM = 4'h4;

   function automatic logic is_bus(input state_t s);
      return (s == ST_WSTR) || (s == ST_RD) || (s == ST_WADV);
   endfunction

endpackage

// File: rtl/rand_stream_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         i_req,
   input  logic [$clog2(NREQ)-1:0] i_ptr,
   output logic [NREQ-1:0]         o_gnt,
   output logic [$clog2(NREQ)-1:0] o_idx
);

   localparam int IW = $clog2(NREQ);

   // scan every position once starting at the pointer, wrapping past NREQ-1
   always_comb begin
      int j;
      logic w_hit;
      o_gnt = '0;
      o_idx = '0;
      w_hit = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(i_ptr) + i;
         j = (j >= NREQ) ? j - NREQ : j;
         if (!w_hit && i_req[IW'(j)]) begin
            w_hit = 1'b1;
            o_gnt[IW'(j)] = 1'b1;
            o_idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/rand_stream_sched.sv
// rand_stream_sched: round-robin sharing of one multi-stream RNG bus port among NREQ requesters
module rand_stream_sched
   import rand_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int GAP  = 2,
   parameter int TMO  = 255
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ*10-1:0] stream_i,
   output logic [NREQ-1:0]   done_o,
   output logic              err_o,
   output logic [31:0]       rnd_o,
   output logic              busy_o,
   output logic              m_cs_o,
   output logic              m_cyc_o,
   output logic              m_stb_o,
   output logic              m_we_o,
   output logic [3:0]        m_adr_o,
   output logic [31:0]       m_dat_o,
   input  logic              m_ack_i,
   input  logic [31:0]       m_dat_i
);

   localparam int IW   = $clog2(NREQ);
   localparam int MAXC = (TMO > GAP) ? TMO : GAP;
   localparam int CW   = $clog2(MAXC + 1);

   state_t           r_state;
   state_t           w_nxt;
   ret_state_t       r_ret;
   ret_state_t       w_ret_nxt;
   logic [CW-1:0]    r_cnt;
   logic [IW-1:0]    r_ptr;
   logic [IW-1:0]    w_idx;
   logic [NREQ-1:0]  w_gnt;
   logic [NREQ-1:0]  r_gnt;
   logic [9:0]       w_streams [NREQ];
   logic [9:0]       w_stream;
   logic [9:0]       r_stream;
   logic [9:0]       r_cache;
   logic             r_cvalid;
   logic [31:0]      r_hold;
   logic             r_err;
   logic [NREQ-1:0]  r_done;
   logic             r_err_o;
   logic [31:0]      r_rnd;
   logic             w_any;
   logic             w_bus;
   logic             w_ack;
   logic             w_tmo;
   logic             w_gap_end;
   logic             w_hit_cache;

   for (genvar i = 0; i < NREQ; i++) begin : g_str
      assign w_streams[i] = stream_i[i*10 +: 10];
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req (req_i),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign w_stream    = w_streams[w_idx];
   assign w_any       = |req_i;
   assign w_bus       = is_bus(r_state);
   assign w_ack       = w_bus && m_ack_i;
   assign w_tmo       = w_bus && !m_ack_i && (r_cnt == CW'(TMO - 1));
   assign w_gap_end   = (r_state == ST_GAP) && (r_cnt == CW'(GAP - 1));
   assign w_hit_cache = r_cvalid && (r_cache == w_stream);

   // next state and the state to resume after the following GAP
   always_comb begin
      w_nxt     = r_state;
      w_ret_nxt = r_ret;
      case (r_state)
         ST_IDLE: w_nxt = w_any ? (w_hit_cache ? ST_RD : ST_WSTR) : ST_IDLE;
         ST_WSTR, ST_RD, ST_WADV: begin
            w_nxt     = (w_ack || w_tmo) ? ST_GAP : r_state;
            w_ret_nxt = w_tmo ? ST_DONE :
                        (r_state == ST_WSTR) ? ST_RD :
                        (r_state == ST_RD) ? ST_WADV : ST_DONE;
         end
         ST_GAP:  w_nxt = w_gap_end ? r_ret : ST_GAP;
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   // FSM state, per-state cycle counter, grant capture, stream cache and holding register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_ret    <= ST_IDLE;
         r_cnt    <= '0;
         r_ptr    <= '0;
         r_gnt    <= '0;
         r_stream <= '0;
         r_cache  <= '0;
         r_cvalid <= 1'b0;
         r_hold   <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_ret   <= w_ret_nxt;
         r_cnt   <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
         if (r_state == ST_IDLE && w_any) begin
            r_gnt    <= w_gnt;
            r_stream <= w_stream;
            r_ptr    <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            r_hold   <= '0;
            r_err    <= 1'b0;
         end
         if (r_state == ST_WSTR && w_ack) begin
            r_cache  <= r_stream;
            r_cvalid <= 1'b1;
         end
         if (r_state == ST_RD && w_ack)
            r_hold <= m_dat_i;
         if (w_tmo) begin
            r_err    <= 1'b1;
            r_hold   <= '0;
            r_cvalid <= 1'b0;
         end
      end
   end

   // result outputs change together on the edge entering DONE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_done  <= '0;
         r_err_o <= 1'b0;
         r_rnd   <= '0;
      end else begin
         r_done  <= (w_nxt == ST_DONE) ? r_gnt : '0;
         r_err_o <= (w_nxt == ST_DONE) && r_err;
         if (w_nxt == ST_DONE)
            r_rnd <= r_hold;
      end
   end

   assign done_o  = r_done;
   assign err_o   = r_err_o;
   assign rnd_o   = r_rnd;
   assign busy_o  = (r_state != ST_IDLE);
   assign m_cs_o  = w_bus;
   assign m_cyc_o = w_bus;
   assign m_stb_o = w_bus;
   assign m_we_o  = (r_state == ST_WSTR) || (r_state == ST_WADV);
   assign m_adr_o = (r_state == ST_WSTR) ? RNG_ADR_STREAM : RNG_ADR_VALUE;
   assign m_dat_o = (r_state == ST_WSTR) ? {22'h0, r_stream} : 32'h0;

endmodule

// File: tb/tb_rand_stream_sched.sv
// tb_rand_stream_sched: directed checks of the scheduler against a simple generator model
module tb_rand_stream_sched;

   typedef struct {
      logic        we;
      logic [3:0]  adr;
      logic [31:0] dat;
   } bus_t;

   typedef struct {
      logic [3:0]  d;
      logic [31:0] rnd;
      logic        err;
      int          e;
   } done_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [3:0]  req_i;
   logic [39:0] stream_i;
   logic [3:0]  done_o;
   logic        err_o;
   logic [31:0] rnd_o;
   logic        busy_o;
   logic        m_cs_o, m_cyc_o, m_stb_o, m_we_o;
   logic [3:0]  m_adr_o;
   logic [31:0] m_dat_o;
   logic        m_ack_i = 1'b0;
   logic [31:0] m_dat_i;
   logic [31:0] dat_model;
   logic        hang_rd;

   bus_t  bus_q[$];
   done_t done_q[$];
   int    ncyc = 0;
   int    rd_len = 0;
   int    low_run = 0;
   int    min_gap = 1000;
   logic  prev_we = 1'b0;
   logic  seen_w = 1'b0;
   int    nchk = 0;
   int    nerr = 0;
   int    n0;

   rand_stream_sched #(.NREQ(4), .GAP(2), .TMO(255)) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .req_i    (req_i),
      .stream_i (stream_i),
      .done_o   (done_o),
      .err_o    (err_o),
      .rnd_o    (rnd_o),
      .busy_o   (busy_o),
      .m_cs_o   (m_cs_o),
      .m_cyc_o  (m_cyc_o),
      .m_stb_o  (m_stb_o),
      .m_we_o   (m_we_o),
      .m_adr_o  (m_adr_o),
      .m_dat_o  (m_dat_o),
      .m_ack_i  (m_ack_i),
      .m_dat_i  (m_dat_i)
   );

   always #5 clk_i = ~clk_i;

   assign m_dat_i = dat_model;

   // generator model: ack on the second cycle of a strobe (A=2); reads can be made to hang
   always @(posedge clk_i)
      m_ack_i <= m_cyc_o && m_stb_o && !m_ack_i && !(hang_rd && !m_we_o);

   // monitor: logs acked bus cycles, done pulses, read length and write spacing
   always @(posedge clk_i) begin
      ncyc++;
      if (m_cyc_o && m_ack_i) bus_q.push_back('{m_we_o, m_adr_o, m_dat_o});
      if (m_cyc_o && !m_we_o) rd_len++;
      if (done_o != 4'b0) done_q.push_back('{done_o, rnd_o, err_o, ncyc});
      if (m_we_o) begin
         if (!prev_we && seen_w && low_run < min_gap) min_gap = low_run;
         seen_w  = 1'b1;
         low_run = 0;
      end else begin
         low_run++;
      end
      prev_we = m_we_o;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_dones(input string tag, input int n, input int budget);
      int t = 0;
      while (done_q.size() < n && t < budget) begin
         @(negedge clk_i);
         t++;
      end
      chk(tag, 64'(done_q.size()), 64'(n));
   endtask

   task automatic clear_logs();
      bus_q.delete();
      done_q.delete();
      rd_len  = 0;
      min_gap = 1000;
      seen_w  = 1'b0;
   endtask

   initial begin
      rst_ni    = 1'b0;
      req_i     = 4'b0;
      stream_i  = '0;
      hang_rd   = 1'b0;
      dat_model = 32'hDEADBEEF;
      repeat (2) @(negedge clk_i);
      chk("rst_done", 64'(done_o), 64'h0);
      chk("rst_rnd", 64'(rnd_o), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      chk("rst_bus", {m_cs_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o}, 64'h0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // single request, stream change
      clear_logs();
      stream_i[9:0] = 10'd5;
      req_i = 4'b0001;
      n0 = ncyc;
      wait_dones("t1_done_cnt", 1, 40);
      req_i = 4'b0;
      chk("t1_done", 64'(done_q[0].d), 64'h1);
      chk("t1_rnd", 64'(done_q[0].rnd), 64'hDEADBEEF);
      chk("t1_err", 64'(done_q[0].err), 64'h0);
      chk("t1_lat", 64'(done_q[0].e - n0), 64'd14);
      chk("t1_nbus", 64'(bus_q.size()), 64'd3);
      chk("t1_w4", {bus_q[0].we, bus_q[0].adr, bus_q[0].dat}, {1'b1, 4'h4, 32'd5});
      chk("t1_r0", {bus_q[1].we, bus_q[1].adr}, {1'b0, 4'h0});
      chk("t1_w0", {bus_q[2].we, bus_q[2].adr, bus_q[2].dat}, {1'b1, 4'h0, 32'd0});
      repeat (3) @(negedge clk_i);
      chk("t1_rnd_hold", 64'(rnd_o), 64'hDEADBEEF);

      // same requester, same stream: no stream write
      clear_logs();
      dat_model = 32'h12345678;
      req_i = 4'b0001;
      n0 = ncyc;
      wait_dones("t2_done_cnt", 1, 40);
      req_i = 4'b0;
      chk("t2_lat", 64'(done_q[0].e - n0), 64'd10);
      chk("t2_nbus", 64'(bus_q.size()), 64'd2);
      chk("t2_r0", {bus_q[0].we, bus_q[0].adr}, {1'b0, 4'h0});
      chk("t2_rnd", 64'(done_q[0].rnd), 64'h12345678);

      // async reset in the middle of RD
      clear_logs();
      req_i = 4'b0001;
      for (int t = 0; t < 40 && !(m_cyc_o && !m_we_o); t++) @(negedge clk_i);
      chk("t5_rd_seen", 64'(m_cyc_o && !m_we_o), 64'h1);
      #2 rst_ni = 1'b0;
      #1;
      chk("t5_cyc_drop", 64'(m_cyc_o), 64'h0);
      chk("t5_busy_drop", 64'(busy_o), 64'h0);
      @(negedge clk_i);
      req_i = 4'b0;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      chk("t5_no_done", 64'(done_q.size()), 64'h0);
      chk("t5_rnd_rst", 64'(rnd_o), 64'h0);
      @(negedge clk_i);

      // all four requesting: round robin from pointer 0
      clear_logs();
      dat_model = 32'hA5A50003;
      stream_i = {10'd7, 10'd9, 10'd7, 10'd5};
      req_i = 4'b1111;
      wait_dones("t3_done_cnt", 5, 200);
      req_i = 4'b0;
      chk("t3_g0", 64'(done_q[0].d), 64'h1);
      chk("t3_g1", 64'(done_q[1].d), 64'h2);
      chk("t3_g2", 64'(done_q[2].d), 64'h4);
      chk("t3_g3", 64'(done_q[3].d), 64'h8);
      chk("t3_g4", 64'(done_q[4].d), 64'h1);
      chk("t3_rnd", 64'(done_q[4].rnd), 64'hA5A50003);
      chk("t3_w4_after_rst", {bus_q[0].we, bus_q[0].adr, bus_q[0].dat}, {1'b1, 4'h4, 32'd5});
      chk("t3_w4_req1", {bus_q[3].we, bus_q[3].adr, bus_q[3].dat}, {1'b1, 4'h4, 32'd7});
      chk("t3_we_gap", 64'(min_gap >= 2), 64'h1);

      // read never acknowledged: timeout
      @(negedge clk_i);
      clear_logs();
      hang_rd = 1'b1;
      req_i = 4'b0010;
      n0 = ncyc;
      wait_dones("t4_done_cnt", 1, 400);
      req_i = 4'b0;
      hang_rd = 1'b0;
      chk("t4_done", 64'(done_q[0].d), 64'h2);
      chk("t4_err", 64'(done_q[0].err), 64'h1);
      chk("t4_rnd", 64'(done_q[0].rnd), 64'h0);
      chk("t4_lat", 64'(done_q[0].e - n0), 64'd263);
      chk("t4_rd_len", 64'(rd_len), 64'd255);
      @(negedge clk_i);
      clear_logs();
      req_i = 4'b0010;
      n0 = ncyc;
      wait_dones("t4b_done_cnt", 1, 40);
      req_i = 4'b0;
      chk("t4b_w4", {bus_q[0].we, bus_q[0].adr, bus_q[0].dat}, {1'b1, 4'h4, 32'd7});
      chk("t4b_err", 64'(done_q[0].err), 64'h0);
      chk("t4b_lat", 64'(done_q[0].e - n0), 64'd14);

      // request 2 withdrawn during WADV
      @(negedge clk_i);
      clear_logs();
      req_i = 4'b0100;
      for (int t = 0; t < 60 && !(m_cyc_o && m_we_o && m_adr_o == 4'h0); t++) @(negedge clk_i);
      chk("t6_wadv_seen", 64'(m_cyc_o && m_we_o && m_adr_o == 4'h0), 64'h1);
      req_i = 4'b0;
      wait_dones("t6_done_cnt", 1, 40);
      chk("t6_done", 64'(done_q[0].d), 64'h4);
      repeat (30) @(negedge clk_i);
      chk("t6_no_regrant", 64'(done_q.size()), 64'h1);
      chk("t6_idle", 64'(busy_o), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
